// File: rtl/nocif_dram_wr_rsp_tracker_if.sv
// Write-response tracker bus bundle: completion-queue push from the ingress
// arbiter and the AXI B channel from the NOC.
interface nocif_dram_wr_rsp_tracker_if #(
  parameter int CID_W = 4,
  parameter int BID_W = 8
);
  logic             cq_wr_pvld;
  logic             cq_wr_prdy;
  logic [CID_W-1:0] cq_wr_thread_id;
  logic [2:0]       cq_wr_pd;
  logic             noc2mcif_axi_b_bvalid;
  logic             noc2mcif_axi_b_bready;
  logic [BID_W-1:0] noc2mcif_axi_b_bid;

  modport master (
    output cq_wr_pvld, cq_wr_thread_id, cq_wr_pd,
    output noc2mcif_axi_b_bvalid, noc2mcif_axi_b_bid,
    input  cq_wr_prdy, noc2mcif_axi_b_bready
  );

  modport slave (
    input  cq_wr_pvld, cq_wr_thread_id, cq_wr_pd,
    input  noc2mcif_axi_b_bvalid, noc2mcif_axi_b_bid,
    output cq_wr_prdy, noc2mcif_axi_b_bready
  );
endinterface

// File: rtl/nocif_dram_wr_rsp_tracker.sv
// Per-client write completion queues with outstanding-beat credit limiting;
// AXI B responses pop the matching client queue and raise completion pulses.
module nocif_dram_wr_rsp_tracker #(
  parameter int NUM_CLIENTS = 5,
  parameter int CQ_DEPTH    = 8,
  parameter int CID_W       = 4,
  parameter int BID_W       = 8,
  parameter int OS_W        = 9
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic [7:0]             reg2dp_wr_os_cnt,
  nocif_dram_wr_rsp_tracker_if.slave bus,
  output logic [NUM_CLIENTS-1:0] mcif2client_wr_rsp_complete,
  output logic [OS_W-1:0]        os_cnt_cur,
  output logic                   err_unexp_bid
);

  localparam int PTR_W = $clog2(CQ_DEPTH);
  localparam logic [CID_W:0] NC = (CID_W+1)'(NUM_CLIENTS);

  logic [2:0]             r_mem    [NUM_CLIENTS][CQ_DEPTH];
  logic [PTR_W:0]         r_wr_ptr [NUM_CLIENTS];
  logic [PTR_W:0]         r_rd_ptr [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] r_complete;
  logic [OS_W-1:0]        r_os_cnt;
  logic                   r_err;

  logic [NUM_CLIENTS-1:0] w_full;
  logic [NUM_CLIENTS-1:0] w_empty;
  logic [CID_W-1:0]       w_b_cid;
  logic                   w_push_in_range;
  logic                   w_tgt_full;
  logic                   w_b_empty;
  logic [2:0]             w_head;
  logic [OS_W-1:0]        w_push_beats;
  logic [OS_W-1:0]        w_pop_beats;
  logic [OS_W-1:0]        w_os_sum;
  logic [OS_W-1:0]        w_os_lim;
  logic [OS_W-1:0]        w_os_next;
  logic                   w_prdy;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_unexp;

  assign w_b_cid         = bus.noc2mcif_axi_b_bid[CID_W-1:0];
  assign w_push_in_range = {1'b0, bus.cq_wr_thread_id} < NC;

  // Out-of-range client ids match no queue, so they read as full/empty here.
  always_comb begin
    w_full     = '0;
    w_empty    = '0;
    w_tgt_full = 1'b1;
    w_b_empty  = 1'b1;
    w_head     = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      w_empty[i] = (r_wr_ptr[i] == r_rd_ptr[i]);
      w_full[i]  = (r_wr_ptr[i][PTR_W] != r_rd_ptr[i][PTR_W]) &&
                   (r_wr_ptr[i][PTR_W-1:0] == r_rd_ptr[i][PTR_W-1:0]);
      if (bus.cq_wr_thread_id == CID_W'(i)) w_tgt_full = w_full[i];
      if (w_b_cid == CID_W'(i)) begin
        w_b_empty = w_empty[i];
        w_head    = r_mem[i][r_rd_ptr[i][PTR_W-1:0]];
      end
    end
  end

  assign w_push_beats = OS_W'(bus.cq_wr_pd[1:0]) + OS_W'(1);
  assign w_pop_beats  = OS_W'(w_head[1:0]) + OS_W'(1);
  assign w_os_sum     = r_os_cnt + w_push_beats;
  assign w_os_lim     = OS_W'(reg2dp_wr_os_cnt) + OS_W'(1);

  assign w_prdy  = w_push_in_range && !w_tgt_full && (w_os_sum <= w_os_lim);
  assign w_push  = bus.cq_wr_pvld && w_prdy;
  assign w_pop   = bus.noc2mcif_axi_b_bvalid && !w_b_empty;
  assign w_unexp = bus.noc2mcif_axi_b_bvalid && w_b_empty;

  assign w_os_next = r_os_cnt + (w_push ? w_push_beats : OS_W'(0))
                              - (w_pop  ? w_pop_beats  : OS_W'(0));

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
      end
      r_complete <= '0;
      r_os_cnt   <= '0;
      r_err      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (w_push && bus.cq_wr_thread_id == CID_W'(i)) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
        if (w_pop && w_b_cid == CID_W'(i))              r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
        r_complete[i] <= w_pop && (w_b_cid == CID_W'(i)) && w_head[2];
      end
      r_os_cnt <= w_os_next;
      if (w_unexp) r_err <= 1'b1;
    end
  end

  // Queue storage needs no reset; the pointers define what is valid.
  always_ff @(posedge nvdla_core_clk) begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (w_push && bus.cq_wr_thread_id == CID_W'(i))
        r_mem[i][r_wr_ptr[i][PTR_W-1:0]] <= bus.cq_wr_pd;
    end
  end

  assign bus.cq_wr_prdy            = w_prdy;
  assign bus.noc2mcif_axi_b_bready = 1'b1;
  assign mcif2client_wr_rsp_complete = r_complete;
  assign os_cnt_cur                = r_os_cnt;
  assign err_unexp_bid             = r_err;

endmodule

// File: tb/tb_nocif_dram_wr_rsp_tracker.sv
// Directed vector bench for the write-response tracker: table of single-cycle
// vectors plus hand-written full-queue and mid-operation reset sequences.
module tb_nocif_dram_wr_rsp_tracker;

  logic       clk;
  logic       rst_n;
  logic [7:0] os_lim;
  logic [4:0] complete;
  logic [8:0] os_cur;
  logic       err;

  int n_pass  = 0;
  int n_total = 0;

  nocif_dram_wr_rsp_tracker_if #(.CID_W(4), .BID_W(8)) u_if ();

  nocif_dram_wr_rsp_tracker #(
    .NUM_CLIENTS(5), .CQ_DEPTH(8), .CID_W(4), .BID_W(8), .OS_W(9)
  ) u_dut (
    .nvdla_core_clk              (clk),
    .nvdla_core_rstn             (rst_n),
    .reg2dp_wr_os_cnt            (os_lim),
    .bus                         (u_if.slave),
    .mcif2client_wr_rsp_complete (complete),
    .os_cnt_cur                  (os_cur),
    .err_unexp_bid               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic [3:0] tid;
    logic [2:0] pd;
    logic       b;
    logic [7:0] bid;
    logic [7:0] lim;
    logic       prdy;
    logic [8:0] os;
    logic [4:0] comp;
    logic       err;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(logic push, logic [3:0] tid, logic [2:0] pd, logic b,
                              logic [7:0] bid, logic [7:0] lim, logic prdy,
                              logic [8:0] os, logic [4:0] comp, logic e);
    vec_t v;
    v.push = push; v.tid = tid; v.pd = pd; v.b = b; v.bid = bid; v.lim = lim;
    v.prdy = prdy; v.os = os; v.comp = comp; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic drive(input logic push, input logic [3:0] tid, input logic [2:0] pd,
                       input logic b, input logic [7:0] bid, input logic [7:0] lim);
    u_if.cq_wr_pvld            = push;
    u_if.cq_wr_thread_id       = tid;
    u_if.cq_wr_pd              = pd;
    u_if.noc2mcif_axi_b_bvalid = b;
    u_if.noc2mcif_axi_b_bid    = bid;
    os_lim                     = lim;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 4'd2,  3'b111, 1'b0, 8'h00, 8'd255, 1'b1, 9'd4, 5'b00000, 1'b0);
    vecs[1]  = mk(1'b0, 4'd0,  3'b000, 1'b1, 8'h02, 8'd255, 1'b1, 9'd0, 5'b00100, 1'b0);
    vecs[2]  = mk(1'b0, 4'd0,  3'b000, 1'b0, 8'h00, 8'd255, 1'b1, 9'd0, 5'b00000, 1'b0);
    vecs[3]  = mk(1'b1, 4'd0,  3'b111, 1'b0, 8'h00, 8'd3,   1'b1, 9'd4, 5'b00000, 1'b0);
    vecs[4]  = mk(1'b1, 4'd1,  3'b100, 1'b0, 8'h00, 8'd3,   1'b0, 9'd4, 5'b00000, 1'b0);
    vecs[5]  = mk(1'b1, 4'd1,  3'b100, 1'b1, 8'h00, 8'd3,   1'b0, 9'd0, 5'b00001, 1'b0);
    vecs[6]  = mk(1'b1, 4'd1,  3'b100, 1'b0, 8'h00, 8'd3,   1'b1, 9'd1, 5'b00000, 1'b0);
    vecs[7]  = mk(1'b0, 4'd0,  3'b000, 1'b1, 8'h01, 8'd3,   1'b1, 9'd0, 5'b00010, 1'b0);
    vecs[8]  = mk(1'b1, 4'd0,  3'b011, 1'b0, 8'h00, 8'd255, 1'b1, 9'd4, 5'b00000, 1'b0);
    vecs[9]  = mk(1'b1, 4'd0,  3'b000, 1'b0, 8'h00, 8'd1,   1'b0, 9'd4, 5'b00000, 1'b0);
    vecs[10] = mk(1'b0, 4'd0,  3'b000, 1'b1, 8'h00, 8'd1,   1'b0, 9'd0, 5'b00000, 1'b0);
    vecs[11] = mk(1'b1, 4'd0,  3'b000, 1'b0, 8'h00, 8'd1,   1'b1, 9'd1, 5'b00000, 1'b0);
    vecs[12] = mk(1'b0, 4'd0,  3'b000, 1'b1, 8'h00, 8'd1,   1'b1, 9'd0, 5'b00000, 1'b0);
    vecs[13] = mk(1'b1, 4'd1,  3'b001, 1'b0, 8'h00, 8'd255, 1'b1, 9'd2, 5'b00000, 1'b0);
    vecs[14] = mk(1'b1, 4'd1,  3'b110, 1'b0, 8'h00, 8'd255, 1'b1, 9'd5, 5'b00000, 1'b0);
    vecs[15] = mk(1'b0, 4'd0,  3'b000, 1'b1, 8'h01, 8'd255, 1'b1, 9'd3, 5'b00000, 1'b0);
    vecs[16] = mk(1'b0, 4'd0,  3'b000, 1'b1, 8'h01, 8'd255, 1'b1, 9'd0, 5'b00010, 1'b0);
    vecs[17] = mk(1'b0, 4'd0,  3'b000, 1'b1, 8'h07, 8'd255, 1'b1, 9'd0, 5'b00000, 1'b1);
    vecs[18] = mk(1'b1, 4'd3,  3'b110, 1'b0, 8'h00, 8'd255, 1'b1, 9'd3, 5'b00000, 1'b1);
    vecs[19] = mk(1'b0, 4'd0,  3'b000, 1'b1, 8'h04, 8'd255, 1'b1, 9'd3, 5'b00000, 1'b1);
    vecs[20] = mk(1'b1, 4'd0,  3'b001, 1'b1, 8'h03, 8'd255, 1'b1, 9'd2, 5'b01000, 1'b1);
    vecs[21] = mk(1'b0, 4'd0,  3'b000, 1'b1, 8'h00, 8'd255, 1'b1, 9'd0, 5'b00000, 1'b1);
    vecs[22] = mk(1'b1, 4'd5,  3'b000, 1'b0, 8'h00, 8'd255, 1'b0, 9'd0, 5'b00000, 1'b1);
    vecs[23] = mk(1'b1, 4'd15, 3'b000, 1'b0, 8'h00, 8'd255, 1'b0, 9'd0, 5'b00000, 1'b1);
    vecs[24] = mk(1'b1, 4'd4,  3'b100, 1'b1, 8'h04, 8'd255, 1'b1, 9'd1, 5'b00000, 1'b1);
    vecs[25] = mk(1'b0, 4'd0,  3'b000, 1'b1, 8'h04, 8'd255, 1'b1, 9'd0, 5'b10000, 1'b1);
    vecs[26] = mk(1'b1, 4'd2,  3'b100, 1'b0, 8'h00, 8'd255, 1'b1, 9'd1, 5'b00000, 1'b1);
    vecs[27] = mk(1'b0, 4'd0,  3'b000, 1'b1, 8'hA2, 8'd255, 1'b1, 9'd0, 5'b00100, 1'b1);

    rst_n = 1'b0;
    drive(1'b0, 4'd0, 3'b000, 1'b0, 8'h00, 8'd255);
    repeat (3) @(posedge clk);
    #1;
    chk("rst os", 32'(os_cur), 32'd0);
    chk("rst comp", 32'(complete), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("bready", 32'(u_if.noc2mcif_axi_b_bready), 32'd1);
    chk("idle prdy", 32'(u_if.cq_wr_prdy), 32'd1);

    for (int i = 0; i < 28; i++) begin
      drive(vecs[i].push, vecs[i].tid, vecs[i].pd, vecs[i].b, vecs[i].bid, vecs[i].lim);
      #1;
      chk($sformatf("v%0d prdy", i), 32'(u_if.cq_wr_prdy), 32'(vecs[i].prdy));
      tick();
      chk($sformatf("v%0d os", i), 32'(os_cur), 32'(vecs[i].os));
      chk($sformatf("v%0d comp", i), 32'(complete), 32'(vecs[i].comp));
      chk($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].err));
    end

    // Fill client 4, then pop and push it in the same cycle while full.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 4'd4, 3'b000, 1'b0, 8'h00, 8'd255);
      #1;
      chk($sformatf("fill%0d prdy", k), 32'(u_if.cq_wr_prdy), 32'd1);
      tick();
    end
    chk("full os", 32'(os_cur), 32'd8);
    drive(1'b1, 4'd4, 3'b000, 1'b0, 8'h00, 8'd255);
    #1;
    chk("full prdy", 32'(u_if.cq_wr_prdy), 32'd0);
    tick();
    chk("full refused os", 32'(os_cur), 32'd8);
    drive(1'b1, 4'd4, 3'b000, 1'b1, 8'h04, 8'd255);
    #1;
    chk("full pushpop prdy", 32'(u_if.cq_wr_prdy), 32'd0);
    tick();
    chk("full pushpop os", 32'(os_cur), 32'd7);
    drive(1'b1, 4'd4, 3'b100, 1'b0, 8'h00, 8'd255);
    #1;
    chk("refill prdy", 32'(u_if.cq_wr_prdy), 32'd1);
    tick();
    chk("refill os", 32'(os_cur), 32'd8);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 4'd0, 3'b000, 1'b1, 8'h04, 8'd255);
      tick();
      chk($sformatf("drain%0d comp", k), 32'(complete), (k == 7) ? 32'h10 : 32'h0);
    end
    chk("drain os", 32'(os_cur), 32'd0);
    chk("drain err", 32'(err), 32'd1);

    // Asynchronous reset with an entry in flight discards it.
    drive(1'b1, 4'd2, 3'b111, 1'b0, 8'h00, 8'd255);
    tick();
    chk("pre-rst os", 32'(os_cur), 32'd4);
    drive(1'b0, 4'd0, 3'b000, 1'b0, 8'h00, 8'd255);
    rst_n = 1'b0;
    #1;
    chk("async rst os", 32'(os_cur), 32'd0);
    chk("async rst err", 32'(err), 32'd0);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 4'd0, 3'b000, 1'b1, 8'h02, 8'd255);
    tick();
    chk("post-rst err", 32'(err), 32'd1);
    chk("post-rst comp", 32'(complete), 32'd0);
    chk("post-rst os", 32'(os_cur), 32'd0);
    drive(1'b0, 4'd0, 3'b000, 1'b0, 8'h00, 8'd255);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
